alu_sequencer: RTL and testbench

- Multi-cycle arithmetic controller sitting between gencon and the datapath.
- Accepts one signed 16-bit operation per valid/ready handshake (add, sub or mul).
- Time-shares a single (WIDTH+1)-bit adder for add, sub and every shift-add multiply step.
- Returns a result and flags over a second valid/ready handshake.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/alu_shared_adder.sv | 20 ++
 rtl/alu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared width, opcode and state definitions for the ALU sequencer and its adder.
package calc_pkg;

  localparam int CALC_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b100
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDSUB   = 3'd1,
    ST_MUL_STEP = 3'd2,
    ST_MUL_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } alu_seq_state_t;

endpackage

// File: rtl/alu_shared_adder.sv
// Combinational (WIDTH+1)-bit adder with optional B inversion and carry-in;
// the single arithmetic resource time-shared by the sequencer.
module alu_shared_adder
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_inv_b,
  input  logic           i_cin,
  output logic [WIDTH:0] o_sum
);

  logic [WIDTH:0] w_b_eff;

  assign w_b_eff = i_inv_b ? ~i_b : i_b;
  assign o_sum   = i_a + w_b_eff + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle signed add/sub/shift-add-multiply sequencer with valid/ready on both sides.
// Build option: define ALU_SATURATE_EN to clamp overflowing results instead of wrapping.
//
// state       | meaning
// ST_IDLE     | op_ready high, waiting for a request
// ST_ADDSUB   | one pass through the shared adder for A+B or A-B
// ST_MUL_STEP | one shift-add iteration per cycle, counter 0..MUL_STEPS-1
// ST_MUL_FIX  | apply product sign, compute overflow
// ST_DONE     | res_valid high, outputs held until res_ready
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH     = CALC_WIDTH,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       opcode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             err_opcode
);

  localparam int                 CNT_W       = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(MUL_STEPS - 1);
  localparam logic [2*WIDTH-1:0] MAG_POS_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAG_NEG_MAX = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  alu_seq_state_t     r_state;
  logic [WIDTH-1:0]   r_a, r_b, r_mcand, r_result;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sub, r_neg, r_overflow, r_err;

  logic [WIDTH:0]     w_add_a, w_add_b, w_sum;
  logic               w_add_inv, w_add_cin;
  logic [WIDTH-1:0]   w_abs_a, w_mf_wrap, w_as_res, w_mf_res;
  logic               w_as_ov, w_mneg, w_mf_ov;

  // In IDLE the adder is otherwise unused, so it negates op_a to form |A| at accept.
  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_inv = 1'b0;
    w_add_cin = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_add_b   = {op_a[WIDTH-1], op_a};
        w_add_inv = 1'b1;
        w_add_cin = 1'b1;
      end
      ST_ADDSUB: begin
        w_add_a   = {r_a[WIDTH-1], r_a};
        w_add_b   = {r_b[WIDTH-1], r_b};
        w_add_inv = r_sub;
        w_add_cin = r_sub;
      end
      ST_MUL_STEP: begin
        w_add_a = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
        w_add_b = {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
      end
      ST_MUL_FIX: begin
        w_add_b   = {1'b0, r_prod[WIDTH-1:0]};
        w_add_inv = 1'b1;
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  alu_shared_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a     (w_add_a),
    .i_b     (w_add_b),
    .i_inv_b (w_add_inv),
    .i_cin   (w_add_cin),
    .o_sum   (w_sum)
  );

  assign w_abs_a   = op_a[WIDTH-1] ? w_sum[WIDTH-1:0] : op_a;
  assign w_as_ov   = (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  assign w_mneg    = r_neg && (r_prod != '0);
  assign w_mf_ov   = w_mneg ? (r_prod > MAG_NEG_MAX) : (r_prod > MAG_POS_MAX);
  assign w_mf_wrap = w_mneg ? w_sum[WIDTH-1:0] : r_prod[WIDTH-1:0];

`ifdef ALU_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_as_res = w_as_ov ? (r_a[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_sum[WIDTH-1:0];
  assign w_mf_res = w_mf_ov ? (w_mneg ? SAT_MIN : SAT_MAX) : w_mf_wrap;
`else
  assign w_as_res = w_sum[WIDTH-1:0];
  assign w_mf_res = w_mf_wrap;
`endif

  // Negative B is loaded as ~B with |A| pre-seeded in the high half:
  // |A|*~B + |A| = |A|*|B|, so no second negation is needed.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_sub      <= 1'b0;
      r_neg      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= (opcode == OP_SUB);
            r_neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_mcand <= w_abs_a;
            r_prod  <= op_b[WIDTH-1] ? {w_abs_a, ~op_b} : {{WIDTH{1'b0}}, op_b};
            r_cnt   <= '0;
            case (opcode)
              OP_ADD, OP_SUB: r_state <= ST_ADDSUB;
              OP_MUL:         r_state <= ST_MUL_STEP;
              default: begin
                r_result   <= '0;
                r_overflow <= 1'b0;
                r_err      <= 1'b1;
                r_state    <= ST_DONE;
              end
            endcase
          end
        end
        ST_ADDSUB: begin
          r_result   <= w_as_res;
          r_overflow <= w_as_ov;
          r_err      <= 1'b0;
          r_state    <= ST_DONE;
        end
        ST_MUL_STEP: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= ST_MUL_FIX;
        end
        ST_MUL_FIX: begin
          r_result   <= w_mf_res;
          r_overflow <= w_mf_ov;
          r_err      <= 1'b0;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready   = (r_state == ST_IDLE);
  assign res_valid  = (r_state == ST_DONE);
  assign result     = r_result;
  assign overflow   = r_overflow;
  assign err_opcode = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes model results at accept,
// monitor pops and compares whenever res_valid is presented.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        op_valid, op_ready, res_valid, res_ready;
  logic [15:0] op_a, op_b, result;
  logic [2:0]  opcode;
  logic        overflow, err_opcode;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .RST        (RST),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .overflow   (overflow),
    .err_opcode (err_opcode)
  );

  typedef struct {
    logic signed [15:0] res;
    logic               ov;
    logic               err;
    int                 lat;
    int                 stall;
    int                 acc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   busy  = 1'b0;
  logic [2:0] opc_tab [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, range test, then wrap or clamp.
  function automatic exp_t model(input logic signed [15:0] a, input logic signed [15:0] b,
                                 input logic [2:0] opc);
    exp_t        e;
    longint      t;
    logic [63:0] tv;
    e.err = 1'b0; e.stall = 0; e.acc = 0;
    case (opc)
      3'b001:  begin t = longint'(a) + longint'(b); e.lat = 2;  end
      3'b010:  begin t = longint'(a) - longint'(b); e.lat = 2;  end
      3'b100:  begin t = longint'(a) * longint'(b); e.lat = 18; end
      default: begin t = 0; e.err = 1'b1; e.lat = 1; end
    endcase
    e.ov  = (t > 32767) || (t < -32768);
    tv    = t;
    e.res = tv[15:0];
`ifdef ALU_SATURATE_EN
    if (e.ov) e.res = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    return e;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      4:       return 16'($urandom_range(0, 511)) - 16'd256;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] opc, input int stall);
    exp_t e;
    int   n;
    @(negedge clk);
    op_a = a; op_b = b; opcode = opc; op_valid = 1'b1;
    n = 0;
    while (op_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_bound", op_ready, 1);
    if (op_ready !== 1'b1) begin
      op_valid = 1'b0;
      return;
    end
    e       = model(a, b, opc);
    e.acc   = cyc;
    e.stall = stall;
    sb.push_back(e);
    @(negedge clk);
    op_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    opcode   = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: compare on first sight of res_valid, optionally stall, then release.
  initial begin
    exp_t e;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (RST === 1'b0 && res_valid === 1'b1) begin
        busy = 1'b1;
        check("result_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("latency", cyc - e.acc, e.lat);
          check("result", $signed(result), e.res);
          check("overflow", overflow, e.ov);
          check("err_opcode", err_opcode, e.err);
          check("op_ready_in_done", op_ready, 0);
          for (int i = 0; i < e.stall; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_result", $signed(result), e.res);
            check("hold_overflow", overflow, e.ov);
            check("hold_not_ready", op_ready, 0);
          end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("left_done", res_valid, 0);
        check("ready_after_done", op_ready, 1);
        busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    opc_tab = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001, 3'b010, 3'b011, 3'b000};
    RST = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; opcode = '0;
    repeat (3) @(negedge clk);
    check("rst_op_ready", op_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_err", err_opcode, 0);
    RST = 1'b0;

    issue(16'd2, 16'd3, 3'b001, 0);
    issue(16'h8000, 16'hFFFF, 3'b001, 0);
    issue(16'd3, 16'd5, 3'b010, 0);
    issue(16'hFFFD, 16'hFFFA, 3'b100, 0);
    issue(16'hFFFF, 16'hFFFF, 3'b100, 0);
    issue(16'd128, 16'd256, 3'b100, 0);
    issue(16'h8000, 16'd1, 3'b100, 0);
    issue(16'd4, 16'd3, 3'b100, 5);
    issue(16'd7, 16'hFFF7, 3'b001, 0);
    issue(16'd1, 16'd2, 3'b011, 0);
    issue(16'd5, 16'd5, 3'b000, 0);
    issue(16'd6, 16'd7, 3'b001, 0);
    issue(16'd0, 16'd0, 3'b100, 1);
    issue(16'h8000, 16'h8000, 3'b100, 0);
    issue(16'h0000, 16'h8000, 3'b010, 0);

    for (int i = 0; i < 40; i++) begin
      issue(rand16(), rand16(), opc_tab[$urandom_range(0, 7)], $urandom_range(0, 3));
    end
    drain();

    issue(16'd2, 16'd3, 3'b001, 0);
    drain();
    issue(16'd100, 16'd100, 3'b100, 0);
    repeat (7) @(posedge clk);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_op_ready", op_ready, 1);
    check("async_rst_res_valid", res_valid, 0);
    check("async_rst_result", result, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_err", err_opcode, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    RST = 1'b0;
    issue(16'd1, 16'd1, 3'b001, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
